// File: rtl/fetch_queue.sv
// fetch_queue: in-order instruction fetch front end feeding the IF/ID register.
// One memory request in flight at a time; responses land in a small FIFO that
// decode drains through out_ready. A branch redirect flushes the FIFO and marks
// any in-flight response as stale so it is discarded when it returns.
module fetch_queue #(
  parameter int unsigned       WIDTH    = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [WIDTH-1:0]  RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [WIDTH-1:0]         imem_addr,
  input  logic                     imem_gnt,
  input  logic                     imem_valid,
  input  logic [WIDTH-1:0]         imem_rdata,
  input  logic                     redirect,
  input  logic [WIDTH-1:0]         redirect_pc,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_pc,
  output logic [WIDTH-1:0]         out_instr,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned OCC_W = CNT_W + 1;

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] instr;
  } entry_t;

  logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [WIDTH-1:0] req_pc_q, req_pc_d;
  logic             outstanding_q, outstanding_d;
  logic             drop_q, drop_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  entry_t           mem [DEPTH];

  logic [OCC_W-1:0] occupancy;
  logic             resp;
  logic             grant;
  logic             push;
  logic             pop;
  logic             not_empty;

  // Request gating: occupancy counts the in-flight slot and ignores a same-cycle pop.
  assign occupancy = OCC_W'(count_q) + OCC_W'(outstanding_q);
  assign imem_req  = !rst && !redirect && (!outstanding_q || imem_valid)
                     && (occupancy < OCC_W'(DEPTH));
  assign imem_addr = fetch_pc_q;
  assign grant     = imem_req && imem_gnt;

  // Response and FIFO handshakes; redirect suppresses both push and pop.
  assign resp      = imem_valid && outstanding_q;
  assign push      = resp && !drop_q && !redirect;
  assign not_empty = (count_q != '0);
  assign out_valid = not_empty && !redirect;
  assign pop       = out_valid && out_ready;

  // Head entry is shown directly; zero when the queue is empty.
  assign out_pc    = not_empty ? mem[rd_ptr_q].pc    : '0;
  assign out_instr = not_empty ? mem[rd_ptr_q].instr : '0;
  assign count     = count_q;

  // Next-state: redirect wins over grant, response and pop.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    req_pc_d      = req_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;

    if (redirect) begin
      count_d    = '0;
      rd_ptr_d   = wr_ptr_q;
      fetch_pc_d = redirect_pc;
      if (outstanding_q && !imem_valid) begin
        drop_d = 1'b1;
      end else begin
        outstanding_d = 1'b0;
        drop_d        = 1'b0;
      end
    end else begin
      if (grant) begin
        req_pc_d      = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + WIDTH'(4);
        outstanding_d = 1'b1;
      end else if (resp) begin
        outstanding_d = 1'b0;
      end

      if (resp && drop_q) begin
        drop_d = 1'b0;
      end

      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      req_pc_q      <= '0;
      outstanding_q <= 1'b0;
      drop_q        <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      req_pc_q      <= req_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  // FIFO storage; contents are only meaningful below count, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= '{pc: req_pc_q, instr: imem_rdata};
    end
  end

  // Occupancy never exceeds the FIFO depth.
  a_count_bound : assert property (@(posedge clk) disable iff (rst)
    count_q <= CNT_W'(DEPTH));

  // A response is never accepted into a full FIFO.
  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    push |-> (count_q < CNT_W'(DEPTH)));

endmodule
